// File: rtl/axi_burst_mem_slave.sv
// rtl/axi_burst_mem_slave.sv - AXI4 burst memory slave with independent read and write channels
module axi_burst_mem_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_W-1:0]     i_awid,
    input  logic [ADDR_W-1:0]   i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [2:0]          i_awsize,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [ID_W-1:0]     o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready,
    input  logic [ID_W-1:0]     i_arid,
    input  logic [ADDR_W-1:0]   i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    output logic [ID_W-1:0]     o_rid,
    output logic [DATA_W-1:0]   o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready
);
    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int LD    = $clog2(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] bound;
        step  = ADDR_W'(1) << size;
        bound = ADDR_W'({1'b0, len} + 9'd1) << size;
        case (burst)
            BURST_INCR: f_next_addr = (addr & ~(step - ADDR_W'(1))) + step;
            BURST_WRAP: f_next_addr = (addr & ~(bound - ADDR_W'(1)))
                                    | ((addr + step) & (bound - ADDR_W'(1)));
            default:    f_next_addr = addr;
        endcase
    endfunction

    function automatic logic f_illegal(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        f_illegal = (burst == 2'b11) || (size > 3'(LB))
                 || ((burst == BURST_WRAP) &&
                     !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic [LD-1:0] f_index(input logic [ADDR_W-1:0] addr);
        f_index = LD'(addr >> LB);
    endfunction

    // Byte lanes belonging to the narrow beat that contains addr.
    function automatic logic [BYTES-1:0] f_lane_mask(input logic [ADDR_W-1:0] addr,
                                                     input logic [2:0] size);
        logic [ADDR_W-1:0] off;
        f_lane_mask = '0;
        off = addr & ADDR_W'(BYTES - 1);
        for (int i = 0; i < BYTES; i++)
            f_lane_mask[i] = ((ADDR_W'(i) ^ off) >> size) == '0;
    endfunction

    w_state_t          r_wstate;
    logic              r_awready, r_wready, r_bvalid;
    logic [1:0]        r_bresp;
    logic [ID_W-1:0]   r_bid;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wlen, r_wbeat;
    logic [2:0]        r_wsize;
    logic [1:0]        r_wburst;
    logic              r_willegal, r_wproto_err;

    logic              w_wlast_bad;
    logic              w_wr_fire;
    logic [BYTES-1:0]  w_wr_lanes;
    logic [LD-1:0]     w_wr_idx;

    assign w_wlast_bad = i_wlast != (r_wbeat == r_wlen);
    assign w_wr_fire   = (r_wstate == W_DATA) && i_wvalid && !r_willegal;
    assign w_wr_lanes  = i_wstrb & f_lane_mask(r_waddr, r_wsize);
    assign w_wr_idx    = f_index(r_waddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate     <= W_IDLE;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_bid        <= '0;
            r_waddr      <= '0;
            r_wlen       <= '0;
            r_wbeat      <= '0;
            r_wsize      <= '0;
            r_wburst     <= '0;
            r_willegal   <= 1'b0;
            r_wproto_err <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (r_awready && i_awvalid) begin
                        r_awready    <= 1'b0;
                        r_wready     <= 1'b1;
                        r_bid        <= i_awid;
                        r_waddr      <= i_awaddr;
                        r_wlen       <= i_awlen;
                        r_wsize      <= i_awsize;
                        r_wburst     <= i_awburst;
                        r_wbeat      <= '0;
                        r_willegal   <= f_illegal(i_awlen, i_awsize, i_awburst);
                        r_wproto_err <= 1'b0;
                        r_wstate     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (i_wvalid) begin
                        r_waddr <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
                        if (w_wlast_bad)
                            r_wproto_err <= 1'b1;
                        if (r_wbeat == r_wlen) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_willegal || r_wproto_err || w_wlast_bad)
                                        ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wbeat <= r_wbeat + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (i_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Memory has no reset so its contents survive a mid-burst abort.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int i = 0; i < BYTES; i++)
                if (w_wr_lanes[i])
                    r_mem[w_wr_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
    end

    r_state_t          r_rstate;
    logic              r_arready, r_rvalid, r_rlast;
    logic [1:0]        r_rresp;
    logic [ID_W-1:0]   r_rid;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_raddr;
    logic [7:0]        r_rlen, r_rbeat;
    logic [2:0]        r_rsize;
    logic [1:0]        r_rburst;
    logic              r_rillegal;

    logic              w_ar_illegal;
    logic [ADDR_W-1:0] w_rnext;

    assign w_ar_illegal = f_illegal(i_arlen, i_arsize, i_arburst);
    assign w_rnext      = f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate   <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rid      <= '0;
            r_rdata    <= '0;
            r_raddr    <= '0;
            r_rlen     <= '0;
            r_rbeat    <= '0;
            r_rsize    <= '0;
            r_rburst   <= '0;
            r_rillegal <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (r_arready && i_arvalid) begin
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rid      <= i_arid;
                        r_raddr    <= i_araddr;
                        r_rlen     <= i_arlen;
                        r_rsize    <= i_arsize;
                        r_rburst   <= i_arburst;
                        r_rbeat    <= '0;
                        r_rillegal <= w_ar_illegal;
                        r_rresp    <= w_ar_illegal ? RESP_SLVERR : RESP_OKAY;
                        r_rdata    <= w_ar_illegal ? '0 : r_mem[f_index(i_araddr)];
                        r_rlast    <= (i_arlen == 8'd0);
                        r_rstate   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (i_rready) begin
                        if (r_rbeat == r_rlen) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rbeat <= r_rbeat + 8'd1;
                            r_raddr <= w_rnext;
                            r_rdata <= r_rillegal ? '0 : r_mem[f_index(w_rnext)];
                            r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;
    assign o_bid     = r_bid;
    assign o_arready = r_arready;
    assign o_rvalid  = r_rvalid;
    assign o_rlast   = r_rlast;
    assign o_rresp   = r_rresp;
    assign o_rid     = r_rid;
    assign o_rdata   = r_rdata;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// tb/tb_axi_burst_mem_slave.sv - randomized self-checking bench for axi_burst_mem_slave
module tb_axi_burst_mem_slave;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;

    axi_burst_mem_slave #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize),
        .i_awburst(awburst), .i_awvalid(awvalid), .o_awready(awready),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
        .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
        .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize),
        .i_arburst(arburst), .i_arvalid(arvalid), .o_arready(arready),
        .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid),
        .i_rready(rready)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl  [DEPTH];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];
    logic [31:0] rcap [256];

    function automatic bit m_legal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        return burst != 2'd3 && size <= 3'd2 &&
               (burst != 2'd2 || len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    endfunction

    // Byte address of beat k, computed directly from the burst rules.
    function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst, input int k);
        longint unsigned aa, step, bound, base;
        aa = a;
        step = 64'd1 << size;
        bound = (longint'(len) + 1) * step;
        case (burst)
            2'd1: return (k == 0) ? a : 32'((aa / step) * step + longint'(k) * step);
            2'd2: begin
                base = (aa / bound) * bound;
                return 32'(base + ((aa - base) + longint'(k) * step) % bound);
            end
            default: return a;
        endcase
    endfunction

    function automatic void m_write_beat(input logic [31:0] a, input logic [2:0] size,
                                         input logic [31:0] d, input logic [3:0] s);
        int step;
        step = 1 << size;
        for (int i = 0; i < 4; i++)
            if (s[i] && (i / step == int'(a[1:0]) / step))
                mdl[a[9:2]][8*i +: 8] = d[8*i +: 8];
    endfunction

    // mode: 0 normal WLAST, 1 WLAST missing on final beat, 2 extra WLAST on beat 0
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int mode, input int gap_max);
        int cyc, gap;
        bit legal;
        logic [1:0] exp_resp;
        legal = m_legal(len, size, burst);
        exp_resp = (legal && mode != 1 && !(mode == 2 && len != 0)) ? 2'b00 : 2'b10;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        cyc = 0;
        while (awready !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        if (cyc >= 200) begin
            n_checks++; n_errors++; awvalid = 1'b0;
            $display("FAIL aw_timeout: awready=%b required 1", awready);
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        n_checks++;
        if (awready !== 1'b0 || wready !== 1'b1) begin
            n_errors++; $display("FAIL aw_accept: awready=%b wready=%b required 0 1", awready, wready);
        end
        for (int k = 0; k <= int'(len); k++) begin
            gap = $urandom_range(gap_max, 0);
            repeat (gap) begin @(posedge clk); #1; end
            wdata = wdat[k]; wstrb = wstb[k]; wvalid = 1'b1;
            wlast = (mode == 1) ? 1'b0 : ((k == int'(len)) || (mode == 2 && k == 0));
            cyc = 0;
            while (wready !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
            if (cyc >= 200) begin
                n_checks++; n_errors++; wvalid = 1'b0;
                $display("FAIL w_timeout: beat %0d wready=%b required 1", k, wready);
                return;
            end
            @(posedge clk); #1;
            wvalid = 1'b0; wlast = 1'b0;
            if (legal) m_write_beat(m_addr(addr, len, size, burst, k), size, wdat[k], wstb[k]);
        end
        n_checks++;
        if (bvalid !== 1'b1 || wready !== 1'b0) begin
            n_errors++; $display("FAIL b_rise: bvalid=%b wready=%b required 1 0", bvalid, wready);
        end
        gap = $urandom_range(gap_max, 0);
        repeat (gap) begin
            @(posedge clk); #1;
            n_checks++;
            if (bvalid !== 1'b1 || bresp !== exp_resp) begin
                n_errors++; $display("FAIL b_hold: bvalid=%b bresp=%0d required 1 %0d", bvalid, bresp, exp_resp);
            end
        end
        n_checks++;
        if (bresp !== exp_resp) begin
            n_errors++; $display("FAIL bresp: got %0d required %0d", bresp, exp_resp);
        end
        n_checks++;
        if (bid !== id) begin
            n_errors++; $display("FAIL bid: got %0h required %0h", bid, id);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            n_errors++; $display("FAIL b_done: bvalid=%b awready=%b required 0 1", bvalid, awready);
        end
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int gap_max);
        int cyc, stall;
        bit legal;
        logic [31:0] a, exp_d;
        logic [1:0] exp_r;
        legal = m_legal(len, size, burst);
        exp_r = legal ? 2'b00 : 2'b10;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        cyc = 0;
        while (arready !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        if (cyc >= 200) begin
            n_checks++; n_errors++; arvalid = 1'b0;
            $display("FAIL ar_timeout: arready=%b required 1", arready);
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            a = m_addr(addr, len, size, burst, k);
            exp_d = legal ? mdl[a[9:2]] : 32'h0;
            stall = $urandom_range(gap_max, 0);
            for (int s = 0; s <= stall; s++) begin
                rready = (s == stall);
                n_checks++;
                if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== exp_r || rid !== id ||
                    rlast !== (k == int'(len))) begin
                    n_errors++;
                    $display("FAIL r_beat%0d: v=%b d=%h resp=%0d id=%h last=%b required 1 %h %0d %h %b",
                             k, rvalid, rdata, rresp, rid, rlast, exp_d, exp_r, id, k == int'(len));
                end
                rcap[k] = rdata;
                @(posedge clk); #1;
            end
            rready = 1'b0;
        end
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_errors++; $display("FAIL r_end: rvalid=%b required 0", rvalid);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata} !== '0) begin
            n_errors++; $display("FAIL reset_outputs: some output nonzero, rdata=%h awready=%b", rdata, awready);
        end
        rst_n = 1'b1;
        n_checks++;
        if (awready !== 1'b0 || arready !== 1'b0) begin
            n_errors++; $display("FAIL ready_early: awready=%b arready=%b required 0 0", awready, arready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            n_errors++; $display("FAIL ready_after_reset: awready=%b arready=%b required 1 1", awready, arready);
        end
    endtask

    task automatic test_fill;
        for (int k = 0; k < 256; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
        axi_write(4'h1, 32'h0, 8'd255, 3'd2, 2'd1, 0, 0);
        axi_read(4'h2, 32'h0, 8'd255, 3'd2, 2'd1, 0);
    endtask

    task automatic test_incr;
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'h11 * (k + 1); wstb[k] = 4'hF; end
        axi_write(4'h3, 32'h10, 8'd3, 3'd2, 2'd1, 0, 2);
        axi_read(4'h9, 32'h10, 8'd3, 3'd2, 2'd1, 0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rcap[k] !== 32'h11 * (k + 1)) begin
                n_errors++; $display("FAIL incr_data%0d: got %h required %h", k, rcap[k], 32'h11 * (k + 1));
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_w [4];
        exp_w = '{32'h1000_0038, 32'h1000_003C, 32'h1000_0030, 32'h1000_0034};
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'h1000_0030 + 4 * k; wstb[k] = 4'hF; end
        axi_write(4'h4, 32'h30, 8'd3, 3'd2, 2'd1, 0, 0);
        axi_read(4'hA, 32'h38, 8'd3, 3'd2, 2'd2, 2);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rcap[k] !== exp_w[k]) begin
                n_errors++; $display("FAIL wrap_data%0d: got %h required %h", k, rcap[k], exp_w[k]);
            end
        end
    endtask

    task automatic test_fixed_strobe;
        wdat[0] = 32'hAAAA_1111; wstb[0] = 4'b0011;
        wdat[1] = 32'h2222_BBBB; wstb[1] = 4'b1100;
        axi_write(4'h5, 32'h20, 8'd1, 3'd2, 2'd0, 0, 1);
        axi_read(4'h6, 32'h20, 8'd0, 3'd2, 2'd1, 0);
        n_checks++;
        if (rcap[0] !== 32'h2222_1111) begin
            n_errors++; $display("FAIL fixed_strobe: got %h required 22221111", rcap[0]);
        end
    endtask

    task automatic test_errors;
        for (int k = 0; k < 4; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
        axi_write(4'h7, 32'h40, 8'd3, 3'd2, 2'd3, 0, 1);
        axi_read(4'h7, 32'h40, 8'd3, 3'd2, 2'd1, 0);
        axi_write(4'h8, 32'h50, 8'd3, 3'd2, 2'd1, 1, 1);
        axi_write(4'h8, 32'h60, 8'd3, 3'd2, 2'd1, 2, 0);
        axi_read(4'hB, 32'h50, 8'd3, 3'd2, 2'd1, 0);
        axi_read(4'hC, 32'h70, 8'd3, 3'd3, 2'd1, 2);
        axi_read(4'hD, 32'h70, 8'd2, 3'd2, 2'd2, 0);
    endtask

    task automatic test_random;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [31:0] addr;
        logic [3:0] id;
        for (int it = 0; it < 25; it++) begin
            id = 4'($urandom); addr = $urandom;
            burst = 2'($urandom_range(3, 0));
            size = 3'($urandom_range(3, 0));
            if (burst == 2'd2) len = 8'((2 << $urandom_range(3, 0)) - 1);
            else len = 8'($urandom_range(15, 0));
            for (int k = 0; k < 16; k++) begin wdat[k] = $urandom; wstb[k] = 4'($urandom); end
            axi_write(id, addr, len, size, burst, 0, 2);
            axi_read(~id, addr, len, size, burst, 2);
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 8; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
        fork
            axi_write(4'hE, 32'h100, 8'd7, 3'd2, 2'd1, 0, 3);
            axi_read(4'hF, 32'h200, 8'd7, 3'd2, 2'd1, 3);
        join
        axi_read(4'h3, 32'h100, 8'd7, 3'd2, 2'd1, 0);
    endtask

    task automatic test_reset_mid_burst;
        int cyc;
        araddr = 32'h10; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1; arid = 4'h5; arvalid = 1'b1;
        cyc = 0;
        while (arready !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1 || rlast !== 1'b0) begin
            n_errors++; $display("FAIL mid_burst_pre: rvalid=%b rlast=%b required 1 0", rvalid, rlast);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata} !== '0) begin
            n_errors++; $display("FAIL mid_reset_outputs: rvalid=%b rdata=%h rid=%h required 0", rvalid, rdata, rid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (arready !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset_early: arready=%b required 0", arready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset_release: arready=%b rvalid=%b required 1 0", arready, rvalid);
        end
        axi_read(4'h5, 32'h10, 8'd3, 3'd2, 2'd1, 1);
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        test_reset();
        test_fill();
        test_incr();
        test_wrap();
        test_fixed_strobe();
        test_errors();
        test_random();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_burst_mem_slave.md
# axi_burst_mem_slave

- AXI4 memory-mapped slave with internal word-addressed RAM.
- Full burst support: FIXED, INCR and WRAP bursts, narrow transfers (AxSIZE), byte strobes and transaction IDs.
- Protocol-error reporting through BRESP/RRESP.
- Independent read and write channels, each with its own state machine. One outstanding transaction per direction.
- Sits behind the interconnect as the generic memory target used by the AXI master testbenches.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width; power of two, 8..256. BYTES = DATA_W/8.
- ID_W, 4, AxID/xID width.
- DEPTH, 256, memory depth in words; power of two.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/8/3/2  write address fields. AWVALID in 1; AWREADY out 1.
- WDATA/WSTRB/WLAST  in  DATA_W/BYTES/1  write data. WVALID in 1; WREADY out 1.
- BID/BRESP  out  ID_W/2  write response. BVALID out 1; BREADY in 1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/8/3/2  read address fields. ARVALID in 1; ARREADY out 1.
- RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data. RVALID out 1; RREADY in 1.

## Operation
- **Addressing:** word index = addr[log2(BYTES)+log2(DEPTH)-1 : log2(BYTES)]. Upper bits are ignored, so the memory aliases modulo DEPTH words.
- **Beat size and step:** step = 1<<AxSIZE bytes. Each channel keeps a running byte address and a beat counter from 0 to AxLEN.
- **Next address:**
  - FIXED: unchanged.
  - INCR: (addr & ~(step-1)) + step. The first beat may be unaligned; later beats are aligned.
  - WRAP: bound = (AxLEN+1)*step; next = (addr & ~(bound-1)) | ((addr+step) & (bound-1)).
- **Illegal requests, answered with SLVERR (2'b10):**
  - AxBURST = 2'b11;
  - AxSIZE > log2(BYTES);
  - WRAP with AxLEN not in {1,3,7,15}.
- **Handling of illegal requests:** the full burst is still consumed (write) or produced (read). Memory is never written. Read data is 0.
- **Write FSM:** W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: AWREADY=1. On AW handshake, latch the AW fields and go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes byte lanes where WSTRB[i]=1, masked to the lanes of the current narrow beat. The address then advances.
  - On the handshake with beat == AWLEN, go to W_RESP.
  - Protocol error: WLAST=1 on a non-final beat, or WLAST=0 on the final beat. This sets a sticky error and gives BRESP=SLVERR, but the data is still written.
  - W_RESP: BVALID=1, BID=latched AWID, BRESP=OKAY (2'b00) or SLVERR. On BREADY, go to W_IDLE.
- **Read FSM:** R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ARREADY=1. On AR handshake, latch the AR fields and load RDATA from mem[index(ARADDR)].
  - R_DATA: RVALID=1, RID=latched ARID, RLAST = (beat == ARLEN).
  - Each R handshake advances the address and reloads RDATA with the next beat.
  - The handshake on the last beat returns to R_IDLE.
- **Read data lanes:** full-width word; the master selects lanes.
- **Read/write same word, same edge:** the read returns the old data (registered read before write).
- **Concurrency:** the read and write channels are fully concurrent.

## Timing
- **Reset (rst_n=0):**
  - All outputs are 0: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP, BID, RID, RDATA.
  - Both FSMs go to idle and the beat counters clear.
  - Memory contents are not reset.
- **Ready after reset:** a ready-enable flop sets on the first rising edge after rst_n deasserts. AWREADY and ARREADY rise at that edge.
- **Mid-burst reset:** the burst is aborted immediately with no response. Memory writes already done are kept.
- **AW handshake at edge N:** AWREADY=0 and WREADY=1 from edge N. The first W beat can be accepted at edge N+1.
- **Write response:** BVALID rises at the edge that accepts the last W beat. AWREADY returns at the B handshake edge. Minimum write transaction is AW + LEN+1 W beats + 1 B cycle.
- **AR handshake at edge N:** RVALID=1 with valid RDATA from edge N. The first R beat is in cycle N+1, and beats then run back-to-back while RREADY=1.
- **Stability under stall:** RDATA, RRESP, RID and RLAST stay stable while RVALID=1 and RREADY=0. BVALID and BRESP stay stable until BREADY.
- **No combinational paths:** no input→output path. All outputs are registered or decoded from the state registers.

## Test plan
- **INCR write then read:** AWADDR=0x10, LEN=3, SIZE=2, data 0x11..0x44, WSTRB=F.
  - Write: BRESP=OKAY, BID=AWID.
  - Read back with the same burst: RDATA 0x11,0x22,0x33,0x44; RLAST only on beat 4; RID=ARID.
- **WRAP read:** ARADDR=0x38, LEN=3, SIZE=2. Addresses accessed are 0x38, 0x3C, 0x30, 0x34.
- **FIXED and strobes:** FIXED write to 0x20, LEN=1, with WSTRB=4'b0011 data 0xAAAA_1111, then 4'b1100 data 0x2222_BBBB. A read of 0x20 returns 0x2222_1111.
- **Errors:**
  - AWBURST=2'b11: BRESP=SLVERR and memory unchanged.
  - WLAST missing on the final beat: BRESP=SLVERR.
  - ARSIZE=3 with DATA_W=32: RRESP=SLVERR on every beat, RDATA=0.
- **Backpressure:** random RREADY/BREADY stalls; outputs hold stable, no beat is lost or duplicated. Concurrent AW and AR traffic completes independently.
- **Reset mid-burst:** assert rst_n=0 during beat 2 of a 4-beat read. All outputs are 0; ARREADY=1 the first edge after release; a new burst completes normally.
